// File: rtl/data_sram_responder_if.sv
// Data SRAM request/response bundle between the execute-stage requester and the memory model.
// en qualifies a request in the cycle it is high; there is no ready, so every request is taken,
// and rvalid/err pulse exactly one cycle after the request they answer.
interface data_sram_responder_if;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        data_sram_rvalid;
    logic        data_sram_err;

    modport master (
        output data_sram_en,
        output data_sram_wen,
        output data_sram_addr,
        output data_sram_wdata,
        input  data_sram_rdata,
        input  data_sram_rvalid,
        input  data_sram_err
    );

    modport slave (
        input  data_sram_en,
        input  data_sram_wen,
        input  data_sram_addr,
        input  data_sram_wdata,
        output data_sram_rdata,
        output data_sram_rvalid,
        output data_sram_err
    );
endinterface

// File: rtl/data_sram_responder.sv
// Single-port synchronous data memory answering the data SRAM bus: byte-lane writes,
// one-cycle reads, out-of-range error pulses and accepted read/write counters.
module data_sram_responder #(
    parameter logic [31:0] ADDR_BASE  = 32'h1c00_0000,
    parameter int          DEPTH_LOG2 = 12,
    parameter string       INIT_FILE  = ""
) (
    input  logic                       clk,
    input  logic                       reset,
    data_sram_responder_if.slave       bus,
    output logic [31:0]                rd_count,
    output logic [31:0]                wr_count
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [31:0]           mem [DEPTH];
    logic [31:0]           off;
    logic                  in_range;
    logic [DEPTH_LOG2-1:0] idx;
    logic                  is_write;
    logic                  unused_off_bits;

    // Below-base addresses wrap to huge offsets, so the explicit >= test keeps them out.
    assign off             = bus.data_sram_addr - ADDR_BASE;
    assign in_range        = (bus.data_sram_addr >= ADDR_BASE) && (off[31:DEPTH_LOG2+2] == '0);
    assign idx             = off[DEPTH_LOG2+1:2];
    assign is_write        = |bus.data_sram_wen;
    assign unused_off_bits = ^off[1:0];

    // Storage has no reset; gating everything on en keeps idle-cycle X on wen/addr harmless.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.data_sram_rdata  <= '0;
            bus.data_sram_rvalid <= 1'b0;
            bus.data_sram_err    <= 1'b0;
            rd_count             <= '0;
            wr_count             <= '0;
        end else begin
            bus.data_sram_rvalid <= 1'b0;
            bus.data_sram_err    <= 1'b0;
            if (bus.data_sram_en) begin
                if (!in_range) begin
                    bus.data_sram_err <= 1'b1;
                    if (!is_write) begin
                        bus.data_sram_rdata  <= '0;
                        bus.data_sram_rvalid <= 1'b1;
                    end
                end else if (is_write) begin
                    for (int i = 0; i < 4; i++) begin
                        if (bus.data_sram_wen[i]) begin
                            mem[idx][8*i +: 8] <= bus.data_sram_wdata[8*i +: 8];
                        end
                    end
                    wr_count <= wr_count + 32'd1;
                end else begin
                    bus.data_sram_rdata  <= mem[idx];
                    bus.data_sram_rvalid <= 1'b1;
                    rd_count             <= rd_count + 32'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: directed scenarios plus randomized traffic against a word-map model.
module tb_data_sram_responder;
    localparam logic [31:0] BASE       = 32'h1c00_0000;
    localparam int          DEPTH_LOG2 = 12;
    localparam longint      SPAN       = 4 * (longint'(1) << DEPTH_LOG2);

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] rd_count;
    logic [31:0] wr_count;

    data_sram_responder_if bus();

    data_sram_responder #(
        .ADDR_BASE (BASE),
        .DEPTH_LOG2(DEPTH_LOG2),
        .INIT_FILE ("")
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .rd_count(rd_count),
        .wr_count(wr_count)
    );

    // clock / reset
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model: word map keyed by word number, expected response state
    bit [31:0]   mem_m [int];
    bit [31:0]   m_rdata;
    bit          m_rvalid;
    bit          m_err;
    bit [31:0]   m_rd;
    bit [31:0]   m_wr;
    logic [31:0] exp_q [$];

    function automatic void model_reset();
        m_rdata  = '0;
        m_rvalid = 1'b0;
        m_err    = 1'b0;
        m_rd     = '0;
        m_wr     = '0;
        exp_q.delete();
    endfunction

    function automatic void model_req(bit en, bit [3:0] wen, bit [31:0] addr, bit [31:0] wdata);
        longint    a;
        int        w;
        bit        inr;
        bit [31:0] mask;
        bit [31:0] old;
        a   = {32'h0, addr};
        inr = (a >= {32'h0, BASE}) && (a < {32'h0, BASE} + SPAN);
        w   = int'((a - {32'h0, BASE}) / 4);
        m_rvalid = 1'b0;
        m_err    = 1'b0;
        if (!en) return;
        if (!inr) begin
            m_err = 1'b1;
            if (wen == 4'h0) begin
                m_rdata  = '0;
                m_rvalid = 1'b1;
                exp_q.push_back(32'h0);
            end
            return;
        end
        if (wen == 4'h0) begin
            m_rdata  = mem_m.exists(w) ? mem_m[w] : 32'h0;
            m_rvalid = 1'b1;
            m_rd     = m_rd + 1;
            exp_q.push_back(m_rdata);
        end else begin
            mask     = {{8{wen[3]}}, {8{wen[2]}}, {8{wen[1]}}, {8{wen[0]}}};
            old      = mem_m.exists(w) ? mem_m[w] : 32'h0;
            mem_m[w] = (old & ~mask) | (wdata & mask);
            m_wr     = m_wr + 1;
        end
    endfunction

    // drivers: called at a falling edge, return at the next falling edge with outputs settled
    task automatic drive(input bit en, input bit [3:0] wen, input bit [31:0] addr, input bit [31:0] wdata);
        bus.data_sram_en    = en;
        bus.data_sram_wen   = wen;
        bus.data_sram_addr  = addr;
        bus.data_sram_wdata = wdata;
        model_req(en, wen, addr, wdata);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        bus.data_sram_en = 1'b0;
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        bus.data_sram_en    = 1'b0;
        bus.data_sram_wen   = 4'h0;
        bus.data_sram_addr  = 32'h0;
        bus.data_sram_wdata = 32'h0;
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        checks++; if (bus.data_sram_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=%h", bus.data_sram_rdata, 32'h0); end
        checks++; if (bus.data_sram_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got=%b exp=0", bus.data_sram_rvalid); end
        checks++; if (bus.data_sram_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", bus.data_sram_err); end
        checks++; if (rd_count !== 32'h0) begin errors++; $display("FAIL reset_rd_count got=%0d exp=0", rd_count); end
        checks++; if (wr_count !== 32'h0) begin errors++; $display("FAIL reset_wr_count got=%0d exp=0", wr_count); end
        reset = 1'b0;
    endtask

    task automatic test_write_read();
        do_reset();
        drive(1'b1, 4'hF, 32'h1c00_0010, 32'hDEAD_BEEF);
        checks++; if (bus.data_sram_rvalid !== 1'b0) begin errors++; $display("FAIL wr_rvalid got=%b exp=0", bus.data_sram_rvalid); end
        checks++; if (wr_count !== 32'd1) begin errors++; $display("FAIL wr_count1 got=%0d exp=1", wr_count); end
        drive(1'b1, 4'h0, 32'h1c00_0010, 32'h0);
        checks++; if (bus.data_sram_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_data got=%h exp=%h", bus.data_sram_rdata, 32'hDEAD_BEEF); end
        checks++; if (bus.data_sram_rvalid !== 1'b1) begin errors++; $display("FAIL rd_rvalid got=%b exp=1", bus.data_sram_rvalid); end
        checks++; if (rd_count !== 32'd1 || wr_count !== 32'd1) begin errors++; $display("FAIL rw_counts got=%0d/%0d exp=1/1", rd_count, wr_count); end
    endtask

    task automatic test_merge();
        drive(1'b1, 4'hF, BASE + 32'h20, 32'h1122_3344);
        drive(1'b1, 4'b0100, BASE + 32'h20, 32'hAAAA_AAAA);
        drive(1'b1, 4'b0011, BASE + 32'h21, 32'h5566_5566);
        drive(1'b1, 4'h0, BASE + 32'h22, 32'h0);
        checks++; if (bus.data_sram_rdata !== 32'h11AA_5566) begin errors++; $display("FAIL merge got=%h exp=%h", bus.data_sram_rdata, 32'h11AA_5566); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 3; i++) drive(1'b1, 4'hF, BASE + 32'(4 * i), 32'(i));
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'h0, BASE + 32'(4 * i), 32'h0);
            checks++; if (bus.data_sram_rvalid !== 1'b1 || bus.data_sram_rdata !== 32'(i)) begin
                errors++; $display("FAIL b2b_read%0d got=%b/%h exp=1/%h", i, bus.data_sram_rvalid, bus.data_sram_rdata, 32'(i));
            end
        end
        checks++; if (rd_count !== 32'd3) begin errors++; $display("FAIL b2b_rd_count got=%0d exp=3", rd_count); end
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        checks++; if (bus.data_sram_rvalid !== 1'b0) begin errors++; $display("FAIL b2b_idle_rvalid got=%b exp=0", bus.data_sram_rvalid); end
    endtask

    task automatic test_out_of_range();
        do_reset();
        drive(1'b1, 4'h0, 32'h1bff_fffc, 32'h0);
        checks++; if (bus.data_sram_err !== 1'b1 || bus.data_sram_rvalid !== 1'b1 || bus.data_sram_rdata !== 32'h0) begin
            errors++; $display("FAIL oor_read got err=%b rvalid=%b rdata=%h exp 1/1/0", bus.data_sram_err, bus.data_sram_rvalid, bus.data_sram_rdata);
        end
        drive(1'b1, 4'hF, BASE + 32'h4000, 32'hFFFF_FFFF);
        checks++; if (bus.data_sram_err !== 1'b1 || bus.data_sram_rvalid !== 1'b0 || bus.data_sram_rdata !== 32'h0) begin
            errors++; $display("FAIL oor_write got err=%b rvalid=%b rdata=%h exp 1/0/0", bus.data_sram_err, bus.data_sram_rvalid, bus.data_sram_rdata);
        end
        checks++; if (rd_count !== 32'h0 || wr_count !== 32'h0) begin errors++; $display("FAIL oor_counts got=%0d/%0d exp=0/0", rd_count, wr_count); end
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        checks++; if (bus.data_sram_err !== 1'b0) begin errors++; $display("FAIL oor_err_pulse got=%b exp=0", bus.data_sram_err); end
        drive(1'b1, 4'h0, BASE, 32'h0);
        checks++; if (bus.data_sram_rdata !== 32'h0) begin errors++; $display("FAIL oor_storage got=%h exp=%h", bus.data_sram_rdata, 32'h0); end
    endtask

    task automatic test_idle_garbage();
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 4'hF, BASE + 32'(4 * $urandom_range(0, 2)), $urandom);
            checks++; if (bus.data_sram_rvalid !== 1'b0 || bus.data_sram_err !== 1'b0) begin
                errors++; $display("FAIL idle_outputs cycle %0d got rvalid=%b err=%b exp 0/0", i, bus.data_sram_rvalid, bus.data_sram_err);
            end
        end
        bus.data_sram_en   = 1'b0;
        bus.data_sram_wen  = 'x;
        bus.data_sram_addr = 'x;
        @(posedge clk);
        @(negedge clk);
        checks++; if (rd_count !== m_rd || wr_count !== m_wr) begin errors++; $display("FAIL idle_counts got=%0d/%0d exp=%0d/%0d", rd_count, wr_count, m_rd, m_wr); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'h0, BASE + 32'(4 * i), 32'h0);
            checks++; if (bus.data_sram_rdata !== 32'(i)) begin errors++; $display("FAIL idle_storage%0d got=%h exp=%h", i, bus.data_sram_rdata, 32'(i)); end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(1'b1, 4'hF, BASE + 32'h14, 32'h5555_AAAA);
        drive(1'b1, 4'h0, BASE + 32'h14, 32'h0);
        bus.data_sram_en    = 1'b1;
        bus.data_sram_wen   = 4'hF;
        bus.data_sram_addr  = BASE + 32'h14;
        bus.data_sram_wdata = 32'h1234_5678;
        #2 reset = 1'b1;
        model_reset();
        #1;
        checks++; if (bus.data_sram_rdata !== 32'h0 || bus.data_sram_rvalid !== 1'b0 || bus.data_sram_err !== 1'b0) begin
            errors++; $display("FAIL async_outputs got rdata=%h rvalid=%b err=%b exp 0/0/0", bus.data_sram_rdata, bus.data_sram_rvalid, bus.data_sram_err);
        end
        checks++; if (rd_count !== 32'h0 || wr_count !== 32'h0) begin errors++; $display("FAIL async_counts got=%0d/%0d exp=0/0", rd_count, wr_count); end
        @(posedge clk);
        @(negedge clk);
        bus.data_sram_en = 1'b0;
        reset = 1'b0;
        drive(1'b1, 4'h0, BASE + 32'h14, 32'h0);
        checks++; if (bus.data_sram_rdata !== 32'h5555_AAAA || bus.data_sram_rvalid !== 1'b1) begin
            errors++; $display("FAIL async_word5 got=%h/%b exp=%h/1", bus.data_sram_rdata, bus.data_sram_rvalid, 32'h5555_AAAA);
        end
        checks++; if (rd_count !== 32'd1 || wr_count !== 32'd0) begin errors++; $display("FAIL async_after_counts got=%0d/%0d exp=1/0", rd_count, wr_count); end
    endtask

    task automatic test_random();
        bit [31:0] addr;
        bit [3:0]  wen;
        int        w;
        int        r;
        logic [31:0] exp;
        do_reset();
        for (int i = 0; i < 16; i++) drive(1'b1, 4'hF, BASE + 32'(4 * i), $urandom);
        drive(1'b1, 4'hF, BASE + 32'h3FFC, $urandom);
        for (int n = 0; n < 300; n++) begin
            r   = $urandom_range(0, 9);
            wen = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            w   = ($urandom_range(0, 16) == 16) ? 4095 : $urandom_range(0, 15);
            addr = BASE + 32'(4 * w) + 32'($urandom_range(0, 3));
            if (r >= 8) begin
                case ($urandom_range(0, 3))
                    0:       addr = BASE - 32'd4;
                    1:       addr = BASE + 32'h4000;
                    2:       addr = 32'($urandom_range(0, 32'h1bff_ffff));
                    default: addr = BASE + 32'h4000 + 32'($urandom_range(0, 32'h0fff_ffff));
                endcase
            end
            drive(r >= 2, wen, addr, $urandom);
            checks++; if (bus.data_sram_rvalid !== m_rvalid || bus.data_sram_err !== m_err) begin
                errors++; $display("FAIL rand_flags op %0d got rvalid=%b err=%b exp %b/%b", n, bus.data_sram_rvalid, bus.data_sram_err, m_rvalid, m_err);
            end
            checks++; if (rd_count !== m_rd || wr_count !== m_wr) begin
                errors++; $display("FAIL rand_counts op %0d got=%0d/%0d exp=%0d/%0d", n, rd_count, wr_count, m_rd, m_wr);
            end
            if (m_rvalid) begin
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
            end else begin
                exp = m_rdata;
            end
            checks++; if (bus.data_sram_rdata !== exp) begin
                errors++; $display("FAIL rand_rdata op %0d got=%h exp=%h", n, bus.data_sram_rdata, exp);
            end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rand_leftover got=%0d exp=0", exp_q.size()); end
    endtask

    // final report
    initial begin
        test_reset();
        test_write_read();
        test_merge();
        test_back_to_back();
        test_out_of_range();
        test_idle_garbage();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
